// File: rtl/uart_pkg.sv
// Shared types and constants for the UART sender/receiver pair.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned DEFAULT_CLK_PER_BIT = 868;

  function automatic logic parity_bit(input logic [7:0] b, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: free-runs while enabled and pulses tick on the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_sender.sv
// UART transmitter pulling bytes from the sender buffer via sender_ready/in_valid.
module uart_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int unsigned PARITY      = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       sender_ready,
  output logic       txd,
  output logic       busy
);

  uart_state_t r_state;
  logic [7:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic        r_parity;
  logic        r_txd;

  logic w_tick;
  logic w_load;
  logic w_busy;

  assign sender_ready = (r_state == ST_REQ);
  assign w_busy       = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign busy         = w_busy;
  assign txd          = r_txd;
  assign w_load       = (r_state == ST_WAIT) && in_valid;

  uart_baud_counter #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .CLK   (CLK),
    .reset (reset),
    .clear (w_load),
    .enable(w_busy),
    .tick  (w_tick)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ:  r_state <= ST_WAIT;
        ST_WAIT: begin
          if (in_valid) begin
            // Parity latched from the loaded byte; the shift register is consumed later.
            r_shift   <= in_data;
            r_parity  <= parity_bit(in_data, PARITY);
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_state   <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_txd     <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                r_txd   <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_txd     <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_txd     <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Four sender instances (plain, even, odd, two-stop) fed by a byte-buffer model and checked by a frame decoder.
module tb_uart_sender;

  localparam int unsigned CPB = 4;
  localparam int unsigned PAR_T  [4] = '{0, 2, 1, 0};
  localparam int unsigned STOP_T [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst      [4];
  logic [7:0] in_data  [4];
  logic       in_valid [4];
  logic       sr       [4];
  logic       txd      [4];
  logic       busy     [4];

  // feed entries: {valid, byte}; expected entries: {bit9, byte}, bit9 = parity or first stop bit
  logic [8:0] feed_q [4][$];
  logic [8:0] exp_q  [4][$];
  int         nframes[4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_sender #(
      .CLK_PER_BIT(CPB),
      .PARITY     (PAR_T[g]),
      .STOP_BITS  (STOP_T[g])
    ) u_dut (
      .CLK         (clk),
      .reset       (rst[g]),
      .in_data     (in_data[g]),
      .in_valid    (in_valid[g]),
      .sender_ready(sr[g]),
      .txd         (txd[g]),
      .busy        (busy[g])
    );

    // Buffer model: registered output updates on the edge that ends REQ.
    initial begin
      logic [8:0] ent;
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
      forever begin
        @(posedge clk);
        if (sr[g]) begin
          if (feed_q[g].size() > 0) begin
            ent = feed_q[g].pop_front();
            in_valid[g] <= ent[8];
            in_data[g]  <= ent[7:0];
          end else begin
            in_valid[g] <= 1'b0;
          end
        end
      end
    end

    // Frame decoder and protocol monitor.
    initial begin
      logic [63:0] cap;
      int          cnt, nslot;
      bit          active, chk_next, hold_ok, stop_ok;
      logic        d1, d2;
      logic [7:0]  rx;
      logic [8:0]  e;
      cap = '0; cnt = 0; active = 0; chk_next = 0; d1 = 0; d2 = 0;
      nslot = 10 + ((PAR_T[g] != 0) ? 1 : 0) + int'(STOP_T[g]) - 1;
      forever begin
        @(negedge clk);
        if (rst[g]) begin
          active = 0; chk_next = 0; cnt = 0;
        end else begin
          if (chk_next) begin
            check("ready_after_stop", g, sr[g], 1);
            chk_next = 0;
          end
          if (sr[g]) check("ready_proto", g, {busy[g], d1}, 0);
          if (busy[g]) begin
            if (!active) begin
              active = 1; cnt = 0;
              check("start_latency", g, {d2, d1}, 2'b10);
            end
            if (cnt < 64) cap[cnt] = txd[g];
            cnt++;
          end else if (active) begin
            active = 0;
            check("frame_len", g, cnt, 4 * nslot);
            hold_ok = 1;
            for (int s = 0; s < nslot; s++)
              for (int k = 1; k < 4; k++)
                if (cap[4*s+k] !== cap[4*s]) hold_ok = 0;
            check("bit_hold", g, hold_ok, 1);
            check("start_bit", g, cap[2], 0);
            for (int b = 0; b < 8; b++) rx[b] = cap[4*(b+1)+2];
            stop_ok = 1;
            for (int s = nslot - int'(STOP_T[g]); s < nslot; s++)
              if (cap[4*s+2] !== 1'b1) stop_ok = 0;
            check("stop_bits", g, stop_ok, 1);
            check("frame_expected", g, exp_q[g].size() > 0, 1);
            if (exp_q[g].size() > 0) begin
              e = exp_q[g].pop_front();
              check("data", g, rx, e[7:0]);
              check("bit9", g, cap[38], e[8]);
            end
            nframes[g]++;
            check("idle_gap", g, {sr[g], txd[g]}, 2'b01);
            chk_next = 1;
          end
        end
        d2 = d1;
        d1 = sr[g];
      end
    end
  end

  task automatic check_cadence(input int g);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("cadence", g, sr[g], (i % 3 == 0) ? 1 : 0);
    end
  endtask

  task automatic wait_empty(input int g, input int budget);
    int n = 0;
    while ((exp_q[g].size() != 0 || busy[g]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", g, n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf0;
    for (int g = 0; g < 4; g++) begin
      rst[g] = 1'b1;
      nframes[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_txd", g, txd[g], 1);
      check("rst_busy", g, busy[g], 0);
      check("rst_ready", g, sr[g], 0);
    end
    for (int g = 0; g < 4; g++) rst[g] = 1'b0;
    check_cadence(0);

    // 0xA5, no parity, one stop bit
    exp_q[0].push_back({1'b1, 8'hA5});
    feed_q[0].push_back({1'b1, 8'hA5});
    wait_empty(0, 400);

    // parity and two-stop variants in parallel
    exp_q[1].push_back({1'b0, 8'h03});
    exp_q[1].push_back({1'b1, 8'h07});
    feed_q[1].push_back({1'b1, 8'h03});
    feed_q[1].push_back({1'b1, 8'h07});
    exp_q[2].push_back({1'b1, 8'h03});
    feed_q[2].push_back({1'b1, 8'h03});
    exp_q[3].push_back({1'b1, 8'hFF});
    feed_q[3].push_back({1'b1, 8'hFF});
    for (int g = 1; g < 4; g++) wait_empty(g, 400);

    // word 0x12345678 from the buffer, retire round, then empty
    nf0 = nframes[0];
    foreach (feed_q[0][i]) check("feed_idle", 0, 1, 0);
    exp_q[0].push_back({1'b1, 8'h12});
    exp_q[0].push_back({1'b1, 8'h34});
    exp_q[0].push_back({1'b1, 8'h56});
    exp_q[0].push_back({1'b1, 8'h78});
    feed_q[0].push_back({1'b1, 8'h12});
    feed_q[0].push_back({1'b1, 8'h34});
    feed_q[0].push_back({1'b1, 8'h56});
    feed_q[0].push_back({1'b1, 8'h78});
    feed_q[0].push_back({1'b0, 8'h00});
    wait_empty(0, 1000);
    repeat (30) @(negedge clk);
    check("word_frames", 0, nframes[0] - nf0, 4);
    check("retire_consumed", 0, feed_q[0].size(), 0);
    check("starved_busy", 0, busy[0], 0);

    // reset during data bit 3 of 0x5A
    exp_q[0].push_back({1'b1, 8'h5A});
    feed_q[0].push_back({1'b1, 8'h5A});
    begin
      int n = 0;
      while (!busy[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("abort_frame_started", 0, n < 50, 1);
    end
    repeat (17) @(negedge clk);
    check("abort_pre_busy", 0, busy[0], 1);
    rst[0] = 1'b1;
    void'(exp_q[0].pop_front());
    @(negedge clk);
    check("abort_txd", 0, txd[0], 1);
    check("abort_busy", 0, busy[0], 0);
    check("abort_ready", 0, sr[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    check_cadence(0);
    exp_q[0].push_back({1'b1, 8'h3C});
    feed_q[0].push_back({1'b1, 8'h3C});
    wait_empty(0, 400);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
